// File: rtl/nonrestoring_divider_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock plus one
// remainder-correction cycle, with start/busy/done handshake and divide-by-zero flag.
module nonrestoring_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     a_shift;
  logic [WIDTH:0]     a_step;
  logic [WIDTH:0]     a_fix;
  logic [WIDTH:0]     m_ext;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    m_ext       = {1'b0, m_q};
    a_shift     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_step      = a_q[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
    a_fix       = a_q[WIDTH] ? (a_q + m_ext) : a_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d   = '0;
          q_d   = dividend;
          m_d   = divisor;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      // The sign of the new partial remainder decides both the next
      // operation and the quotient bit shifted in.
      RUN: begin
        a_d   = a_step;
        q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        a_d         = a_fix;
        quotient_d  = q_q;
        remainder_d = a_fix[WIDTH-1:0];
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// Directed bench for nonrestoring_divider_seq: WIDTH=8 vector table plus
// multi-cycle corner sequences, and one WIDTH=16 instance.
module tb_nonrestoring_divider_seq;

  typedef struct {
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] exp_quot;
    logic [7:0] exp_rem;
    logic       exp_dbz;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  logic        start16;
  logic [15:0] dividend16;
  logic [15:0] divisor16;
  logic        busy16;
  logic        done16;
  logic [15:0] quotient16;
  logic [15:0] remainder16;
  logic        div_by_zero16;

  int checks;
  int errors;
  logic overlap;

  nonrestoring_divider_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  nonrestoring_divider_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
    .div_by_zero(div_by_zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((busy && done) || (busy16 && done16)) overlap = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulse start for one accepting edge; returns at the negedge after that edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedges since the accepting edge until done, and busy cycles seen.
  task automatic waitDone(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  vec_t vecs[6];
  int   lat;
  int   bcnt;
  int   pulses;

  initial begin
    checks     = 0;
    errors     = 0;
    overlap    = 1'b0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    start16    = 1'b0;
    dividend16 = '0;
    divisor16  = '0;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 10, 9};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 10, 9};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 10, 9};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 10, 9};
    vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1,  0};
    vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 10, 9};

    rst = 1'b1;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quot", quotient, 0);
    checkOutput("reset_rem", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor);
      waitDone(lat, bcnt);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_quot", i), quotient, vecs[i].exp_quot);
      checkOutput($sformatf("v%0d_rem", i), remainder, vecs[i].exp_rem);
      checkOutput($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_width", i), done, 0);
    end

    // A start while busy must be ignored entirely.
    applyStimulus(8'd200, 8'd7);
    repeat (2) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat = 4;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ignore_latency", lat, 10);
    checkOutput("ignore_quot", quotient, 28);
    checkOutput("ignore_rem", remainder, 4);
    countDone(15, pulses);
    checkOutput("ignore_no_second_done", pulses, 0);

    // Start held high: second operands accepted on the DONE edge.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd6;
    waitDone(lat, bcnt);
    checkOutput("b2b_first_latency", lat, 10);
    checkOutput("b2b_first_quot", quotient, 11);
    checkOutput("b2b_first_rem", remainder, 1);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_spacing", lat, 10);
    checkOutput("b2b_second_quot", quotient, 8);
    checkOutput("b2b_second_rem", remainder, 2);

    // Asynchronous reset in the middle of a division.
    applyStimulus(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_quot", quotient, 0);
    checkOutput("abort_rem", remainder, 0);
    checkOutput("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    countDone(14, pulses);
    checkOutput("abort_no_done", pulses, 0);
    applyStimulus(8'd12, 8'd5);
    waitDone(lat, bcnt);
    checkOutput("after_abort_latency", lat, 10);
    checkOutput("after_abort_quot", quotient, 2);
    checkOutput("after_abort_rem", remainder, 2);

    // WIDTH=16 instance.
    @(negedge clk);
    dividend16 = 16'd60000;
    divisor16  = 16'd7;
    start16    = 1'b1;
    @(negedge clk);
    start16    = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w16_latency", lat, 18);
    checkOutput("w16_quot", quotient16, 8571);
    checkOutput("w16_rem", remainder16, 3);
    checkOutput("w16_dbz", div_by_zero16, 0);

    checkOutput("busy_done_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonrestoring_divider_seq.md
# nonrestoring_divider_seq

Multi-cycle, parametrised unsigned non-restoring divider. One quotient bit is produced per clock, and one correction cycle follows. Operands are captured on a start pulse and results are flagged with a one-cycle done pulse. It is the clocked, width-generic successor to the lab's 2-bit combinational divider. It adds explicit divide-by-zero reporting and a start/busy/done handshake for use inside datapaths and FSM-driven lab top levels.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled on a rising edge of clk, and accepted only when busy is 0.
- dividend  input  WIDTH  unsigned dividend, captured on accepted start.
- divisor  input  WIDTH  unsigned divisor, captured on accepted start.
- busy  output  1  high while a division is in progress (states RUN, FIX).
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; 1 when the last accepted divisor was 0.

## Operation
- Internal registers:
  - A: signed partial remainder, WIDTH+1 bits.
  - Q: WIDTH bits, initially the dividend, shifts into the quotient.
  - M: WIDTH bits, the divisor.
  - cnt: iteration counter, $clog2(WIDTH+1) bits.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE with start=1 (accepted start):
  - Load A=0, Q=dividend, M=divisor, and clear div_by_zero.
  - If divisor==0, go to DONE and set quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
  - Otherwise set cnt=WIDTH and go to RUN.
- RUN, one iteration per cycle:
  - Shift {A,Q} left by one. A takes Q's MSB.
  - If the pre-shift A[WIDTH] is 0, A = shifted A − {1'b0,M}; otherwise A = shifted A + {1'b0,M}.
  - Set Q[0] = ~A[WIDTH] (the new sign).
  - Decrement cnt. When cnt reaches 0 in that cycle, go to FIX.
- FIX, one cycle:
  - If A[WIDTH]==1, then A = A + {1'b0,M}.
  - Load quotient=Q and remainder=A[WIDTH-1:0], then go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Go to IDLE, unless start=1, which is accepted (back-to-back operation).
- IDLE with start=0: hold.
- A start while busy=1 is ignored: no effect on state, operands, or outputs.
- quotient, remainder, and div_by_zero hold their values until the next result load (FIX, or a zero-divisor start).
- Arithmetic: all adds/subtracts are WIDTH+1 bits wide, two's complement, and wrap. After correction the remainder lies in 0..M−1. Results equal floor(dividend/divisor) and dividend mod divisor for all nonzero divisors.

## Timing
- Reset (asynchronous, any time): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and A/Q/M/cnt=0.
- A reset asserted mid-operation aborts the division. No done pulse is produced, and outputs return to reset values immediately.
- Normal latency: for a start accepted at edge k, busy is 1 from after edge k until edge k+WIDTH+1. done is high in the cycle following edge k+WIDTH+1, so done rises WIDTH+2 cycles after start was sampled.
- Divide-by-zero latency: done is high in the cycle following the accepting edge (1 cycle). busy stays 0.
- Throughput: with start held high, one result every WIDTH+2 cycles (normal) or every cycle (zero divisor).
- done and busy are never high together. Outputs change only on clk edges or on rst assertion.

## Test plan
- WIDTH=8, 200/7 -> quotient=28, remainder=4, div_by_zero=0. done exactly 10 cycles after start; busy high for 9 cycles.
- WIDTH=8, 5/9 (final correction path) -> quotient=0, remainder=5. Also 255/1 -> quotient=255, remainder=0. Also 255/255 -> quotient=1, remainder=0.
- WIDTH=8, 77/0 -> quotient=255, remainder=77, div_by_zero=1. done 1 cycle after start; busy never asserted. A following 9/3 clears the flag -> quotient 3, remainder 0.
- Start pulsed during busy with different operands (e.g. 10/3 while 200/7 runs) -> ignored. Result is 28 r4, and no second done.
- Start held high continuously with 100/9 then 50/6 -> two done pulses 10 cycles apart. Results 11 r1, then 8 r2.
- rst asserted at cycle 4 of a 200/7 division -> all outputs 0 immediately. No done pulse. The next start of 12/5 gives 2 r2 with normal latency. Repeat the 200/7 case with WIDTH=16: 60000/7 -> quotient 8571, remainder 3, done 18 cycles after start.
